// File: rtl/rf_pkg.sv
// Shared constants and source encoding for the register-file writeback path.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback commit.
module rf_scoreboard #(
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                hazard1,
  output logic                hazard2,
  output logic [NUM_REGS-1:0] pending,
  output logic                sb_err
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                err_q;
  logic                same_cycle_clear;
  logic                dup_set;

  // Set is applied after clear so a newly issued writer survives the old writer's commit.
  always_comb begin
    pending_nxt = pending_q;
    if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (sb_set) pending_nxt[sb_set_addr] = 1'b1;
  end

  assign same_cycle_clear = wr_en && (wr_addr == sb_set_addr);
  assign dup_set          = sb_set && pending_q[sb_set_addr] && !same_cycle_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      if (dup_set) err_q <= 1'b1;
    end
  end

  // No bypass: a write in flight still reads as pending until its commit edge.
  assign hazard1 = pending_q[rd_addr1];
  assign hazard2 = pending_q[rd_addr2];
  assign pending = pending_q;
  assign sb_err  = err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
module rf_wb_arbiter #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_req,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_gnt,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_gnt,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                hazard1,
  output logic                hazard2,
  output logic [NUM_REGS-1:0] pending,
  output logic                sb_err
);

  import rf_pkg::*;

  src_e              rr_ptr;
  logic              contested;
  logic              gnt_any_p0;
  logic [ADDR_W-1:0] waddr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  assign contested = alu_req && mem_req;

  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (contested) begin
      if (rr_ptr == SRC_ALU) alu_gnt = 1'b1;
      else                   mem_gnt = 1'b1;
    end else begin
      alu_gnt = alu_req;
      mem_gnt = mem_req;
    end
  end

  assign gnt_any_p0 = alu_gnt || mem_gnt;
  assign waddr_p0   = mem_gnt ? mem_addr : alu_addr;
  assign wdata_p0   = mem_gnt ? mem_data : alu_data;

  // Pointer only advances when both sources competed, handing priority to the loser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= SRC_MEM;
    end else if (contested) begin
      rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

  // Stage p0 -> p1: grant registered into the write port; addr/data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt_any_p0;
      if (gnt_any_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .wr_en       (vld_p1),
    .wr_addr     (waddr_p1),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .pending     (pending),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_req;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_gnt;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_gnt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;
  logic [31:0] pending;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .alu_req     (alu_req),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_gnt     (alu_gnt),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_gnt     (mem_gnt),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .pending     (pending),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    alu_req = 1'b0; alu_addr = '0; alu_data = '0;
    mem_req = 1'b0; mem_addr = '0; mem_data = '0;
    sb_set = 1'b0; sb_set_addr = '0;
    rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending); end
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err got %0b want 0", sb_err); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_rf_we got %0b want 0", rf_we); end
  endtask

  task automatic test_lone_alu();
    @(negedge clk);
    alu_req = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL lone_alu_gnt got %0b want 1", alu_gnt); end
    n_checks++; if (mem_gnt !== 1'b0) begin n_fail++; $display("FAIL lone_mem_gnt got %0b want 0", mem_gnt); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL lone_rf_we got %0b want 1", rf_we); end
    n_checks++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL lone_rf_waddr got %0d want 3", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lone_rf_wdata got %h want deadbeef", rf_wdata); end
    @(negedge clk);
    alu_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lone_rf_we_drop got %0b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL lone_waddr_hold got %0d want 3", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lone_wdata_hold got %h want deadbeef", rf_wdata); end
  endtask

  task automatic test_contested();
    logic [3:0]  exp_mem;
    logic [4:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    exp_mem = 4'b0101;
    exp_addr[0] = 5'd16; exp_data[0] = 32'hB000_0000;
    exp_addr[1] = 5'd1;  exp_data[1] = 32'hA000_0000;
    exp_addr[2] = 5'd17; exp_data[2] = 32'hB000_0001;
    exp_addr[3] = 5'd2;  exp_data[3] = 32'hA000_0001;
    do_reset();
    alu_req = 1'b1; alu_addr = 5'd1;  alu_data = 32'hA000_0000;
    mem_req = 1'b1; mem_addr = 5'd16; mem_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (mem_gnt !== exp_mem[i] || alu_gnt !== !exp_mem[i]) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d] got alu=%0b mem=%0b want mem=%0b", i, alu_gnt, mem_gnt, exp_mem[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i] || rf_wdata !== exp_data[i]) begin
        n_fail++;
        $display("FAIL rr_write[%0d] got we=%0b a=%0d d=%h want we=1 a=%0d d=%h",
                 i, rf_we, rf_waddr, rf_wdata, exp_addr[i], exp_data[i]);
      end
      @(negedge clk);
      if (exp_mem[i]) begin mem_addr = mem_addr + 5'd1; mem_data = mem_data + 32'd1; end
      else            begin alu_addr = alu_addr + 5'd1; alu_data = alu_data + 32'd1; end
    end
    alu_req = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rr_idle_we got %0b want 0", rf_we); end
  endtask

  task automatic test_hazard();
    do_reset();
    rd_addr1 = 5'd7; rd_addr2 = 5'd8;
    sb_set = 1'b1; sb_set_addr = 5'd7;
    #1;
    n_checks++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL hz_before_set got %0b want 0", hazard1); end
    @(posedge clk); #1;
    n_checks++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL hz_after_set got %0b want 1", hazard1); end
    n_checks++; if (pending !== 32'h0000_0080) begin n_fail++; $display("FAIL hz_pending got %h want 00000080", pending); end
    @(negedge clk);
    sb_set = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL hz_held got %0b want 1", hazard1); end
    @(negedge clk);
    alu_req = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_7777;
    #1;
    n_checks++; if (alu_gnt !== 1'b1) begin n_fail++; $display("FAIL hz_alu_gnt got %0b want 1", alu_gnt); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      n_fail++; $display("FAIL hz_write got we=%0b a=%0d want we=1 a=7", rf_we, rf_waddr);
    end
    n_checks++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL hz_inflight got %0b want 1", hazard1); end
    n_checks++; if (hazard2 !== 1'b0) begin n_fail++; $display("FAIL hz2_other got %0b want 0", hazard2); end
    @(negedge clk);
    alu_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL hz_after_commit got %0b want 0", hazard1); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL hz_pending_clear got %h want 0", pending); end
  endtask

  task automatic test_set_clear_same();
    do_reset();
    sb_set = 1'b1; sb_set_addr = 5'd5;
    @(posedge clk);
    @(negedge clk);
    sb_set = 1'b0;
    alu_req = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_0005;
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
      n_fail++; $display("FAIL sc_write got we=%0b a=%0d want we=1 a=5", rf_we, rf_waddr);
    end
    @(negedge clk);
    alu_req = 1'b0;
    sb_set = 1'b1; sb_set_addr = 5'd5;
    @(posedge clk); #1;
    n_checks++; if (pending[5] !== 1'b1) begin n_fail++; $display("FAIL sc_pending5 got %0b want 1", pending[5]); end
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sc_sb_err got %0b want 0", sb_err); end
    @(negedge clk);
    sb_set = 1'b0;
  endtask

  task automatic test_double_set();
    do_reset();
    sb_set = 1'b1; sb_set_addr = 5'd9;
    @(posedge clk); #1;
    n_checks++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL ds_first_err got %0b want 0", sb_err); end
    @(posedge clk); #1;
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL ds_err got %0b want 1", sb_err); end
    n_checks++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL ds_pending9 got %0b want 1", pending[9]); end
    @(negedge clk);
    sb_set = 1'b0;
    mem_req = 1'b1; mem_addr = 5'd9; mem_data = 32'h0000_0099;
    #1;
    n_checks++; if (mem_gnt !== 1'b1) begin n_fail++; $display("FAIL ds_mem_gnt got %0b want 1", mem_gnt); end
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (pending[9] !== 1'b0) begin n_fail++; $display("FAIL ds_pending9_clear got %0b want 0", pending[9]); end
    n_checks++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL ds_err_sticky got %0b want 1", sb_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sb_set = 1'b1; sb_set_addr = 5'd4;
    alu_req = 1'b1; alu_addr = 5'd12; alu_data = 32'h0000_0C0C;
    @(posedge clk);
    @(negedge clk);
    sb_set = 1'b0; alu_req = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL ar_pre_we got %0b want 1", rf_we); end
    n_checks++; if (pending !== 32'h0000_0010) begin n_fail++; $display("FAIL ar_pre_pending got %h want 00000010", pending); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ar_we_drop got %0b want 0", rf_we); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL ar_pending_clear got %h want 0", pending); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL ar_waddr got %0d want 0", rf_waddr); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ar_stale_we1 got %0b want 0", rf_we); end
    @(posedge clk); #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ar_stale_we2 got %0b want 0", rf_we); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL ar_pending_after got %h want 0", pending); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_lone_alu();
    test_contested();
    test_hazard();
    test_set_clear_same();
    test_double_set();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two writeback sources: ALU results and memory-load results.
- Keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards for the two read ports.
- Sits between the execute/memory stages and the register file; drives the register file's WE, Ain3 and Din directly.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, scoreboard depth; must equal 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- alu_req  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_gnt  out  1  ALU request accepted this cycle.
- mem_req  in  1  load writeback request.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_gnt  out  1  load request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- sb_set  in  1  issue stage marks a destination as pending.
- sb_set_addr  in  ADDR_W  register to mark.
- rd_addr1  in  ADDR_W  register read by port 1.
- rd_addr2  in  ADDR_W  register read by port 2.
- hazard1  out  1  rd_addr1 is not yet safe to read.
- hazard2  out  1  rd_addr2 is not yet safe to read.
- pending  out  NUM_REGS  raw scoreboard vector.
- sb_err  out  1  sticky scoreboard protocol error.

Behaviour:
- Reset (reset=0, async):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0, sb_err=0.
  - RR pointer = MEM.
  - Any in-flight write is dropped.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt=1 on a posedge.
  - gnt is combinational from req and the RR pointer. At most one gnt is high per cycle.
  - A grant is always issued whenever any req is high; there are no idle cycles.
- Arbitration:
  - One requester active: it wins.
  - Both active: the pointer owner wins, then the pointer moves to the other source.
  - The pointer changes only on a contested grant.
- Write timing (1-cycle latency):
  - Grant in cycle N gives rf_we=1 with the granted addr/data registered during cycle N+1.
  - The register file commits at the posedge ending N+1.
  - With no grant in cycle N, rf_we=0 in N+1; rf_waddr and rf_wdata hold their last values.
  - Back-to-back grants produce a write every cycle.
- Scoreboard:
  - On posedge, with sb_set=1: pending[sb_set_addr] <= 1.
  - On posedge, with rf_we=1: pending[rf_waddr] <= 0 (the write commits at this edge).
  - Set and clear on the same address in the same cycle: set wins (a new writer is issued).
  - sb_set to an address whose pending bit is already 1, with no same-cycle clear: sb_err <= 1. sb_err clears only on reset. The pending bit stays 1.
- Hazard (combinational):
  - hazardK = pending[rd_addrK].
  - A write in flight this cycle (rf_we=1, same address) still reports hazard=1, because the register file reads on negedge before the posedge commit.
  - No bypass is provided.
- All 32 registers are writable; register 0 is not special-cased.

Decomposition:
- Shared package rf_pkg:
  - constants DATA_W, ADDR_W, NUM_REGS.
  - encoding of RR pointer: SRC_ALU=0, SRC_MEM=1.
- Sub-module rf_scoreboard holds pending, the set/clear logic, sb_err and the hazard lookups.
- The top level holds the arbiter, the RR pointer and the write-port registers.

Test Plan:
- Reset release → rf_we=0, pending=0, sb_err=0. A lone alu_req (addr=3, data=0xDEADBEEF) gets alu_gnt=1 the same cycle, then rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF the next cycle for exactly 1 cycle.
- Both requesting for 4 cycles from reset → grants in order MEM, ALU, MEM, ALU; rf_we high 4 consecutive cycles with matching addr/data.
- sb_set addr=7, then a read of 7 → hazard1=1 until the posedge where rf_we=1 with rf_waddr=7; hazard1=0 the following cycle.
- sb_set addr=5 in the same cycle that rf_we writes addr 5 → pending[5] stays 1, sb_err=0.
- sb_set addr=9 twice with no intervening write → sb_err=1 and remains 1 after later writes.
- reset=0 asserted mid-cycle while rf_we=1 → rf_we drops immediately and pending clears. After release, no stale write is issued.
